// File: rtl/tow_match_ctrl.sv
`timescale 1ns/1ps
// Match sequencer for the tug-of-war playfield: runs best-of-N rounds, gates key
// edges into the playfield during play, keeps score and declares the winner.
//
// state      | meaning
// ST_IDLE    | waiting for start, playfield held at centre
// ST_CD      | playfield held at centre, countdown running to open play
// ST_PLAY    | play window open, key rising edges forwarded as press pulses
// ST_RND_END | round decided, final LED position frozen for HOLD_CYCLES
// ST_OVER    | match decided, winner shown until the next start
module tow_match_ctrl #(
   parameter int WIN_ROUNDS       = 3,
   parameter int COUNTDOWN_CYCLES = 4,
   parameter int HOLD_CYCLES      = 2
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       start,
   input  logic       key_l,
   input  logic       key_r,
   input  logic       field_win_l,
   input  logic       field_win_r,
   output logic       field_clr,
   output logic       field_en,
   output logic       press_l,
   output logic       press_r,
   output logic [2:0] score_l,
   output logic [2:0] score_r,
   output logic [3:0] countdown,
   output logic       match_over,
   output logic [1:0] match_winner
);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_CD      = 3'd1,
      ST_PLAY    = 3'd2,
      ST_RND_END = 3'd3,
      ST_OVER    = 3'd4
   } state_t;

   localparam logic [3:0] CD_LOAD   = 4'(COUNTDOWN_CYCLES);
   localparam logic [3:0] HOLD_LOAD = 4'(HOLD_CYCLES);
   localparam logic [2:0] WIN_SCORE = 3'(WIN_ROUNDS);

   state_t     state_q, state_d;
   logic [3:0] countdown_q, countdown_d;
   logic [3:0] hold_q, hold_d;
   logic [2:0] score_l_q, score_l_d;
   logic [2:0] score_r_q, score_r_d;
   logic [1:0] match_winner_q, match_winner_d;
   logic       key_l_hist_q, key_l_hist_d;
   logic       key_r_hist_q, key_r_hist_d;
   logic       field_clr_q, field_clr_d;
   logic       field_en_q, field_en_d;
   logic       press_l_q, press_l_d;
   logic       press_r_q, press_r_d;
   logic       match_over_q, match_over_d;

   logic       edge_l, edge_r;
   logic       any_win, win_l_only, win_r_only;
   logic       left_done, right_done;

   always_comb begin
      edge_l     = key_l & ~key_l_hist_q;
      edge_r     = key_r & ~key_r_hist_q;
      any_win    = field_win_l | field_win_r;
      win_l_only = field_win_l & ~field_win_r;
      win_r_only = field_win_r & ~field_win_l;
      left_done  = (score_l_q == WIN_SCORE);
      right_done = (score_r_q == WIN_SCORE);
   end

   always_comb begin
      state_d        = state_q;
      countdown_d    = countdown_q;
      hold_d         = hold_q;
      score_l_d      = score_l_q;
      score_r_d      = score_r_q;
      match_winner_d = match_winner_q;
      press_l_d      = 1'b0;
      press_r_d      = 1'b0;
      // Edge history runs in every state so a key held into PLAY never pulses.
      key_l_hist_d   = key_l;
      key_r_hist_d   = key_r;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d     = ST_CD;
               countdown_d = CD_LOAD;
            end
         end
         ST_CD: begin
            if (countdown_q <= 4'd1) begin
               state_d     = ST_PLAY;
               countdown_d = 4'd0;
            end else begin
               countdown_d = countdown_q - 4'd1;
            end
         end
         ST_PLAY: begin
            if (any_win) begin
               state_d = ST_RND_END;
               hold_d  = HOLD_LOAD;
               if (win_l_only && (score_l_q < WIN_SCORE)) begin
                  score_l_d = score_l_q + 3'd1;
               end
               if (win_r_only && (score_r_q < WIN_SCORE)) begin
                  score_r_d = score_r_q + 3'd1;
               end
            end else begin
               press_l_d = edge_l;
               press_r_d = edge_r;
            end
         end
         ST_RND_END: begin
            if (hold_q <= 4'd1) begin
               hold_d = 4'd0;
               if (left_done || right_done) begin
                  state_d        = ST_OVER;
                  match_winner_d = left_done ? 2'b01 : 2'b10;
               end else begin
                  state_d     = ST_CD;
                  countdown_d = CD_LOAD;
               end
            end else begin
               hold_d = hold_q - 4'd1;
            end
         end
         ST_OVER: begin
            if (start) begin
               state_d        = ST_CD;
               countdown_d    = CD_LOAD;
               score_l_d      = 3'd0;
               score_r_d      = 3'd0;
               match_winner_d = 2'b00;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      field_clr_d  = (state_d == ST_IDLE) || (state_d == ST_CD);
      field_en_d   = (state_d == ST_PLAY);
      match_over_d = (state_d == ST_OVER);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q        <= ST_IDLE;
         countdown_q    <= 4'd0;
         hold_q         <= 4'd0;
         score_l_q      <= 3'd0;
         score_r_q      <= 3'd0;
         match_winner_q <= 2'b00;
         key_l_hist_q   <= 1'b0;
         key_r_hist_q   <= 1'b0;
         field_clr_q    <= 1'b1;
         field_en_q     <= 1'b0;
         press_l_q      <= 1'b0;
         press_r_q      <= 1'b0;
         match_over_q   <= 1'b0;
      end else begin
         state_q        <= state_d;
         countdown_q    <= countdown_d;
         hold_q         <= hold_d;
         score_l_q      <= score_l_d;
         score_r_q      <= score_r_d;
         match_winner_q <= match_winner_d;
         key_l_hist_q   <= key_l_hist_d;
         key_r_hist_q   <= key_r_hist_d;
         field_clr_q    <= field_clr_d;
         field_en_q     <= field_en_d;
         press_l_q      <= press_l_d;
         press_r_q      <= press_r_d;
         match_over_q   <= match_over_d;
      end
   end

   assign field_clr    = field_clr_q;
   assign field_en     = field_en_q;
   assign press_l      = press_l_q;
   assign press_r      = press_r_q;
   assign score_l      = score_l_q;
   assign score_r      = score_r_q;
   assign countdown    = countdown_q;
   assign match_over   = match_over_q;
   assign match_winner = match_winner_q;

endmodule
